// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one RAM port between instruction fetch and data access,
//            round-robin with data-first tie-break, and owns the LL/SC link.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int WORD_W  = 32,
    parameter bit LINK_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic              datomic,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ramready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    localparam logic [WORD_W-1:0] c_SC_OK = {{(WORD_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next_state;
    logic              r_last_d;
    logic              w_next_last_d;
    logic              r_link_valid;
    logic              w_next_link_valid;
    logic [WORD_W-1:0] r_link_addr;
    logic [WORD_W-1:0] w_next_link_addr;

    logic w_dreq;
    logic w_is_ll;
    logic w_is_sc;
    logic w_link_hit;
    logic w_icomplete;
    logic w_dcomplete;

    // dWEN takes priority if the pipeline ever raises both data strobes
    assign w_dreq     = dREN | dWEN;
    assign w_is_ll    = LINK_EN && datomic && dREN && !dWEN;
    assign w_is_sc    = LINK_EN && datomic && dWEN;
    assign w_link_hit = r_link_valid && (daddr == r_link_addr);

    assign iwait = iREN & ~w_icomplete;
    assign dwait = w_dreq & ~w_dcomplete;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_last_d     <= 1'b0;
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
        end else begin
            r_state      <= w_next_state;
            r_last_d     <= w_next_last_d;
            r_link_valid <= w_next_link_valid;
            r_link_addr  <= w_next_link_addr;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_last_d     = r_last_d;
        w_next_link_valid = r_link_valid;
        w_next_link_addr  = r_link_addr;
        ramREN            = 1'b0;
        ramWEN            = 1'b0;
        ramaddr           = '0;
        ramstore          = '0;
        iload             = '0;
        dload             = '0;
        w_icomplete       = 1'b0;
        w_dcomplete       = 1'b0;

        case (r_state)
            IDLE: begin
                if (iREN && w_dreq) begin
                    if (r_last_d) begin
                        w_next_state  = IACC;
                        w_next_last_d = 1'b0;
                    end else begin
                        w_next_state  = DACC;
                        w_next_last_d = 1'b1;
                    end
                end else if (w_dreq) begin
                    w_next_state  = DACC;
                    w_next_last_d = 1'b1;
                end else if (iREN) begin
                    w_next_state  = IACC;
                    w_next_last_d = 1'b0;
                end
            end

            IACC: begin
                if (!iREN) begin
                    w_next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramready) begin
                        iload        = ramload;
                        w_icomplete  = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end

            DACC: begin
                if (!w_dreq) begin
                    w_next_state = IDLE;
                end else if (w_is_sc && !w_link_hit) begin
                    // Failed SC never reaches the RAM and answers at once
                    w_dcomplete       = 1'b1;
                    w_next_link_valid = 1'b0;
                    w_next_state      = IDLE;
                end else if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ramready) begin
                        w_dcomplete  = 1'b1;
                        w_next_state = IDLE;
                        if (w_is_sc) begin
                            dload = c_SC_OK;
                        end
                        if (w_link_hit) begin
                            w_next_link_valid = 1'b0;
                        end
                    end
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = daddr;
                    if (ramready) begin
                        dload        = ramload;
                        w_dcomplete  = 1'b1;
                        w_next_state = IDLE;
                        if (w_is_ll) begin
                            w_next_link_valid = 1'b1;
                            w_next_link_addr  = daddr;
                        end
                    end
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int W = 32;
    localparam logic [1:0] OP_LW = 2'b00;
    localparam logic [1:0] OP_SW = 2'b01;
    localparam logic [1:0] OP_LL = 2'b10;
    localparam logic [1:0] OP_SC = 2'b11;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] exp_load;
        bit           chk_load;
        bit           exp_wen;
        int           exp_cyc;
    } vec_t;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         iREN = 1'b0;
    logic         dREN = 1'b0;
    logic         dWEN = 1'b0;
    logic         datomic = 1'b0;
    logic         ram_rdy = 1'b1;
    logic [W-1:0] iaddr = '0;
    logic [W-1:0] daddr = '0;
    logic [W-1:0] dstore = '0;
    logic         iwait, dwait, ramREN, ramWEN;
    logic [W-1:0] iload, dload, ramaddr, ramstore, ramload;

    logic [W-1:0] mem [0:255];
    int           checks = 0;
    int           failures = 0;
    vec_t         sb_q[$];
    vec_t         tbl[19];

    mem_arbiter #(.WORD_W(W), .LINK_EN(1'b1)) dut (
        .CLK(clk), .nRST(nrst),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .datomic(datomic),
        .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .iload(iload),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ram_rdy)
    );

    always #5 clk = ~clk;

    assign ramload = mem[ramaddr[9:2]];
    always @(posedge clk) begin
        if (ramWEN && ram_rdy) mem[ramaddr[9:2]] <= ramstore;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [W-1:0] addr,
                                input logic [W-1:0] wdata, input logic [W-1:0] exp_load,
                                input bit chk_load, input bit exp_wen);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.exp_load = exp_load;
        v.chk_load = chk_load; v.exp_wen = exp_wen; v.exp_cyc = 2;
        return v;
    endfunction

    // Holds a data request until dwait drops (bounded), then releases it
    task automatic data_xfer(input logic [1:0] op, input logic [W-1:0] addr,
                             input logic [W-1:0] wdata, output logic [W-1:0] got,
                             output bit saw_wen, output int cyc);
        dREN = ~op[0]; dWEN = op[0]; datomic = op[1]; daddr = addr; dstore = wdata;
        saw_wen = 1'b0; cyc = 0; got = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (ramWEN) saw_wen = 1'b1;
            if (!dwait) begin
                got = dload;
                break;
            end
        end
        @(posedge clk); #1;
        dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
    endtask

    task automatic fetch(input logic [W-1:0] addr, output logic [W-1:0] got, output int cyc);
        iREN = 1'b1; iaddr = addr; cyc = 0; got = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (!iwait) begin
                got = iload;
                break;
            end
        end
        @(posedge clk); #1;
        iREN = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        vec_t         e;
        logic [W-1:0] got;
        bit           wen;
        int           cyc;
        sb_q.push_back(v);
        data_xfer(v.op, v.addr, v.wdata, got, wen, cyc);
        e = sb_q.pop_front();
        if (e.chk_load) chk({tag, "_load"}, got, e.exp_load);
        chk({tag, "_wen"}, {31'd0, wen}, {31'd0, e.exp_wen});
        chk({tag, "_cycles"}, W'(cyc), W'(e.exp_cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] got;
        int           cyc;
        logic [1:0]   cexp [8];

        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[16] = 32'h3C01_0001;

        tbl[0]  = mk(OP_LW, 32'h010, 32'h0,         32'hA000_0004, 1, 0);
        tbl[1]  = mk(OP_SW, 32'h010, 32'h1111_2222, 32'h0,         0, 1);
        tbl[2]  = mk(OP_LW, 32'h010, 32'h0,         32'h1111_2222, 1, 0);
        tbl[3]  = mk(OP_LL, 32'h100, 32'h0,         32'hA000_0040, 1, 0);
        tbl[4]  = mk(OP_SC, 32'h100, 32'hAB,        32'h1,         1, 1);
        tbl[5]  = mk(OP_LW, 32'h100, 32'h0,         32'hAB,        1, 0);
        tbl[6]  = mk(OP_SC, 32'h100, 32'hCD,        32'h0,         1, 0);
        tbl[7]  = mk(OP_LW, 32'h100, 32'h0,         32'hAB,        1, 0);
        tbl[8]  = mk(OP_LL, 32'h100, 32'h0,         32'hAB,        1, 0);
        tbl[9]  = mk(OP_SW, 32'h100, 32'h55,        32'h0,         0, 1);
        tbl[10] = mk(OP_SC, 32'h100, 32'h66,        32'h0,         1, 0);
        tbl[11] = mk(OP_LL, 32'h100, 32'h0,         32'h55,        1, 0);
        tbl[12] = mk(OP_SW, 32'h104, 32'h77,        32'h0,         0, 1);
        tbl[13] = mk(OP_SC, 32'h100, 32'h99,        32'h1,         1, 1);
        tbl[14] = mk(OP_LW, 32'h104, 32'h0,         32'h77,        1, 0);
        tbl[15] = mk(OP_LW, 32'h100, 32'h0,         32'h99,        1, 0);
        tbl[16] = mk(OP_LL, 32'h200, 32'h0,         32'hA000_0080, 1, 0);
        tbl[17] = mk(OP_SC, 32'h204, 32'h12,        32'h0,         1, 0);
        tbl[18] = mk(OP_LW, 32'h204, 32'h0,         32'hA000_0081, 1, 0);

        // Reset state with no requests
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_waits", {30'd0, iwait, dwait}, 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        // Lone fetch: grant cycle, then access completes
        iREN = 1'b1; iaddr = 32'h40;
        @(negedge clk);
        chk("fetch_c1_iwait", {31'd0, iwait}, 32'd1);
        chk("fetch_c1_ramREN", {31'd0, ramREN}, 32'd0);
        @(negedge clk);
        chk("fetch_c2_iwait", {31'd0, iwait}, 32'd0);
        chk("fetch_c2_ramREN", {31'd0, ramREN}, 32'd1);
        chk("fetch_c2_ramaddr", ramaddr, 32'h40);
        chk("fetch_c2_iload", iload, 32'h3C01_0001);
        @(posedge clk); #1;
        iREN = 1'b0;

        for (int i = 0; i < 19; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Fetches leave the link untouched
        run_vec(mk(OP_LL, 32'h300, 32'h0, 32'hA000_00C0, 1, 0), "ll300");
        fetch(32'h300, got, cyc);
        chk("fetch300_iload", got, 32'hA000_00C0);
        chk("fetch300_cycles", W'(cyc), 32'd2);
        run_vec(mk(OP_SC, 32'h300, 32'hEE, 32'h1, 1, 1), "sc300");

        // Flush abort during IACC, then a data request
        ram_rdy = 1'b0; iREN = 1'b1; iaddr = 32'h44;
        @(negedge clk);
        @(negedge clk);
        chk("flush_iacc_ramREN", {31'd0, ramREN}, 32'd1);
        chk("flush_iacc_iwait", {31'd0, iwait}, 32'd1);
        @(posedge clk); #1;
        iREN = 1'b0; dREN = 1'b1; daddr = 32'h10; ram_rdy = 1'b1;
        @(negedge clk);
        chk("flush_ramREN", {31'd0, ramREN}, 32'd0);
        chk("flush_iload", iload, 32'd0);
        @(negedge clk);
        chk("flush_idle_dwait", {31'd0, dwait}, 32'd1);
        @(negedge clk);
        chk("flush_d_dwait", {31'd0, dwait}, 32'd0);
        chk("flush_d_dload", dload, 32'h1111_2222);
        @(posedge clk); #1;
        dREN = 1'b0;

        // Reset in the middle of a stalled store
        run_vec(mk(OP_LL, 32'h180, 32'h0, 32'hA000_0060, 1, 0), "ll180");
        ram_rdy = 1'b0; dWEN = 1'b1; daddr = 32'h180; dstore = 32'hDEAD;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_ramWEN_before", {31'd0, ramWEN}, 32'd1);
        @(posedge clk); #1;
        nrst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_ramWEN_after", {31'd0, ramWEN}, 32'd0);
        chk("rstmid_dwait", {31'd0, dwait}, 32'd1);
        @(posedge clk); #1;
        dWEN = 1'b0; nrst = 1'b1; ram_rdy = 1'b1;
        run_vec(mk(OP_SC, 32'h180, 32'h1234, 32'h0, 1, 0), "sc_after_rst");
        run_vec(mk(OP_LW, 32'h180, 32'h0, 32'hA000_0060, 1, 0), "lw180");

        // Contention from reset: D, I, D, I each two cycles
        cexp = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
        nrst = 1'b0; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h10;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("contend_c%0d_iwait_dwait", k), {30'd0, iwait, dwait}, {30'd0, cexp[k]});
        end
        @(posedge clk); #1;
        iREN = 1'b0; dREN = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the pipeline's instruction-fetch requester (iREN) and data requester (dREN/dWEN/datomic, as produced by the decode/control logic).
- Arbitrates round-robin with data-first tie-break, sequences each access through a small FSM, and returns per-requester wait/load signals.
- Owns the LL/SC reservation (link register) so that SC success is decided at the memory side.

Parameters:
WORD_W, 32, data and address width
LINK_EN, 1, 1 = LL/SC reservation active; 0 = datomic ignored, SC behaves as a plain SW

Ports:
CLK  in  1  clock, all state on rising edge
nRST  in  1  synchronous active-low reset
iREN  in  1  instruction read request, held until iwait=0
iaddr  in  WORD_W  instruction address
dREN  in  1  data read request (LW/LL), held until dwait=0
dWEN  in  1  data write request (SW/SC), held until dwait=0
datomic  in  1  qualifies dREN as LL, dWEN as SC
daddr  in  WORD_W  data address
dstore  in  WORD_W  store data
iwait  out  1  1 = instruction request not complete this cycle
iload  out  WORD_W  fetched instruction, valid when iREN & !iwait
dwait  out  1  1 = data request not complete this cycle
dload  out  WORD_W  load data; for SC: 1 success / 0 failure; valid when !dwait
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramready  in  1  RAM completes the driven access this cycle

Behaviour:
- States: IDLE, IACC, DACC. Also registered: last_d (1 = last grant was data), link_valid, link_addr.
- Reset (nRST=0 at a rising edge): state=IDLE, last_d=0, link_valid=0, link_addr=0.
- IDLE: no RAM strobes. ramaddr=0, ramstore=0, iload=0, dload=0.
- Waits are combinational: iwait = iREN & !(state==IACC & ramready). dwait = dreq & !dcomplete, where dreq = dREN|dWEN.
- dREN and dWEN are never both 1 from the pipeline; if they are, dWEN wins.
- Arbitration in IDLE:
  - both pending: grant IACC if last_d=1, else DACC;
  - only dreq: DACC;
  - only iREN: IACC;
  - none: stay IDLE.
  - last_d updates on grant.
  - A grant costs one IDLE cycle; minimum access latency is 2 cycles from request to !wait.
- IACC: ramREN=1, ramaddr=iaddr.
  - On ramready: iload=ramload, iwait=0, next IDLE.
  - If iREN drops (flush): strobes low that cycle, next IDLE, no completion.
- DACC, normal LW/LL: ramREN=1, ramaddr=daddr. On ramready: dload=ramload, next IDLE.
  - LL (LINK_EN & datomic) completion: link_valid=1, link_addr=daddr.
- DACC, normal SW: ramWEN=1, ramaddr=daddr, ramstore=dstore. On ramready: next IDLE.
  - If link_valid & daddr==link_addr: link_valid cleared.
- DACC, SC success (link_valid & daddr==link_addr): behaves as SW. On completion: dload=1, link_valid=0.
- DACC, SC failure: no RAM strobe. dcomplete=1 in the first DACC cycle, dload=0, link_valid=0, next IDLE.
- If dreq drops in DACC: strobes low, next IDLE, link state unchanged.
- Simultaneous LL completion and reset: reset wins.
- A store completion to the linked address always invalidates the link, regardless of requester.
- Instruction fetches never affect the link.
- Address comparison uses the full WORD_W bits.
- Reset asserted mid-access: the access is abandoned, strobes low from the next cycle, and the requester sees wait until it re-requests after reset.

Test Plan:
- Lone fetch: iREN=1, iaddr=0x40, ramready high on 2nd cycle, ramload=0x3C010001 -> iwait low on cycle 2, iload=0x3C010001, ramREN only in IACC.
- Contention: iREN and dREN both held from reset, ramready=1 always -> grants alternate D,I,D,I; each completes every 2 cycles; last_d toggles.
- LL/SC success: LL daddr=0x100, then SC daddr=0x100, dstore=0xAB -> ramWEN with ramstore=0xAB; dload=1; link_valid=0 afterward.
- SC fail by intervening store: LL 0x100, SW 0x100, SC 0x100 -> SC completes in 1 DACC cycle, no ramWEN, dload=0. SW to 0x104 instead -> SC succeeds.
- Flush abort: IACC with ramready=0, iREN dropped -> next cycle IDLE, ramREN=0, no iload; a subsequent dREN is granted immediately.
- Reset mid-DACC: nRST=0 during an SW with ramready=0 -> next cycle state IDLE, ramWEN=0, link_valid=0; a later SC fails.
